bitram_sequencer: RTL

Instruction fetch sequencer that drives the 6-bit address of the 64×1-bit program RAM and consumes its 17-bit combinational read window, where window bit 16 is the bit at the address and bit 0 is the bit at address+16. It holds the program counter and splits each window into a control header and a payload. It resolves unconditional and conditional jumps and hands the payload to the downstream decoder over a valid/ready handshake. It detects halt and out-of-range fetches, and sits between the program RAM and the execute/decode stage.

---
 rtl/bitseq_pkg.sv | 37 +++
 rtl/bitseq_decode.sv | 38 +++
 rtl/bitram_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bitseq_pkg.sv
// Shared types and constants for the program-RAM fetch sequencer.
// Field positions describe the 17-bit read window: bit 16 sits at the fetch address.
package bitseq_pkg;

    localparam int unsigned PC_W   = 6;
    localparam int unsigned WIN_W  = 17;
    localparam int unsigned PAY_W  = 9;

    localparam int unsigned STEP       = 17;
    localparam int unsigned LAST_START = 47;

    localparam logic [PC_W-1:0] STEP_PC = PC_W'(STEP);
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(LAST_START);

    localparam int unsigned J_BIT = 16;
    localparam int unsigned C_BIT = 15;
    localparam int unsigned T_MSB = 14;
    localparam int unsigned T_LSB = 9;
    localparam int unsigned P_MSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Latched copy of a window; the field order mirrors the window bit order.
    typedef struct packed {
        logic             jump;
        logic             cond;
        logic [PC_W-1:0]  target;
        logic [PAY_W-1:0] payload;
    } instr_t;

endpackage

// File: rtl/bitseq_decode.sv
// Combinational window field split, range/halt detection and next-pc selection.
// Latency: zero (pure combinational). Backpressure: none, it holds no state.
module bitseq_decode
    import bitseq_pkg::*;
(
    input  logic [16:0] window,
    input  logic [5:0]  pc,
    input  logic        ir_jump,
    input  logic        ir_cond,
    input  logic [5:0]  ir_target,
    input  logic        cond_flag,
    output logic        win_jump,
    output logic        win_cond,
    output logic [5:0]  win_target,
    output logic [8:0]  win_payload,
    output logic        range_bad,
    output logic        halt_hit,
    output logic [5:0]  next_pc
);

    logic take_jump;

    assign win_jump    = window[J_BIT];
    assign win_cond    = window[C_BIT];
    assign win_target  = window[T_MSB:T_LSB];
    assign win_payload = window[P_MSB:0];

    // A window starting past LAST_START would read beyond the end of the RAM.
    assign range_bad = (pc > LAST_PC);

    // Only an unconditional self-jump is a halt; a conditional one keeps re-issuing.
    assign halt_hit = win_jump && !win_cond && (win_target == pc);

    // Next pc uses the latched instruction, not the live window.
    assign take_jump = ir_jump && (!ir_cond || cond_flag);
    assign next_pc   = take_jump ? ir_target : (pc + STEP_PC);

endmodule

// File: rtl/bitram_sequencer.sv
// Fetch sequencer for the 64x1 program RAM; optional issue counter under BITSEQ_PERF_EN.
// Latency: run or handshake to next instr_valid is two edges (FETCH then ISSUE).
// Backpressure: ISSUE holds valid/payload/pc stable until instr_ready; valid never depends on ready.
module bitram_sequencer
    import bitseq_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        run,
    input  logic [16:0] mem_window,
    output logic [5:0]  mem_address,
    input  logic        cond_flag,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [8:0]  instr_payload,
    output logic [5:0]  pc,
    output logic        halted,
    output logic        fault,
    output logic [15:0] perf_count
);

    state_t      state;
    state_t      state_n;
    instr_t      ir;
    logic [5:0]  pc_q;
    logic        halted_q;
    logic        fault_q;

    logic        win_jump;
    logic        win_cond;
    logic [5:0]  win_target;
    logic [8:0]  win_payload;
    logic        range_bad;
    logic        halt_hit;
    logic [5:0]  next_pc;

    logic        latch_ir;
    logic        handshake;
    logic        set_halt;
    logic        set_fault;

    bitseq_decode u_decode (
        .window      (mem_window),
        .pc          (pc_q),
        .ir_jump     (ir.jump),
        .ir_cond     (ir.cond),
        .ir_target   (ir.target),
        .cond_flag   (cond_flag),
        .win_jump    (win_jump),
        .win_cond    (win_cond),
        .win_target  (win_target),
        .win_payload (win_payload),
        .range_bad   (range_bad),
        .halt_hit    (halt_hit),
        .next_pc     (next_pc)
    );

    always_comb begin
        state_n   = state;
        latch_ir  = 1'b0;
        handshake = 1'b0;
        set_halt  = 1'b0;
        set_fault = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (range_bad) begin
                    state_n   = ST_FAULT;
                    set_fault = 1'b1;
                end else if (halt_hit) begin
                    state_n  = ST_HALT;
                    set_halt = 1'b1;
                end else begin
                    state_n  = ST_ISSUE;
                    latch_ir = 1'b1;
                end
            end
            ST_ISSUE: begin
                // run is only consulted after the handshake, so dropping it never aborts.
                if (instr_ready) begin
                    handshake = 1'b1;
                    state_n   = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT:  state_n = ST_HALT;
            ST_FAULT: state_n = ST_FAULT;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= ST_IDLE;
            pc_q     <= '0;
            ir       <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (latch_ir) begin
                ir <= '{jump: win_jump, cond: win_cond,
                        target: win_target, payload: win_payload};
            end
            if (handshake) begin
                pc_q <= next_pc;
            end
            if (set_halt) begin
                halted_q <= 1'b1;
            end
            if (set_fault) begin
                fault_q <= 1'b1;
            end
        end
    end

`ifdef BITSEQ_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            perf_q <= '0;
        end else if (handshake && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_count = perf_q;
`else
    assign perf_count = '0;
`endif

    assign mem_address   = pc_q;
    assign pc            = pc_q;
    assign instr_valid   = (state == ST_ISSUE);
    assign instr_payload = ir.payload;
    assign halted        = halted_q;
    assign fault         = fault_q;

endmodule
